// File: rtl/fpu_pkg.sv
// Shared fp32 types, constants and the arbiter state encoding.
package fpu_pkg;

  localparam int unsigned FP_W        = 32;
  localparam logic [31:0] FP_QNAN     = 32'hFFFFFFFF;
  localparam logic [7:0]  FP_EXP_INF  = 8'hFF;
  localparam logic [7:0]  FP_EXP_BIAS = 8'd127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        hit;
    logic [31:0] value;
  } fp_special_t;

  // Operand pairs that resolve without the divider; subnormals count as zero.
  function automatic fp_special_t fp_div_special(input fp32_t a, input fp32_t b);
    fp_special_t r;
    logic s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    s      = a.sign ^ b.sign;
    a_zero = (a.exp == 8'd0);
    b_zero = (b.exp == 8'd0);
    a_inf  = (a.exp == FP_EXP_INF) && (a.mant == 23'd0);
    b_inf  = (b.exp == FP_EXP_INF) && (b.mant == 23'd0);
    a_nan  = (a.exp == FP_EXP_INF) && (a.mant != 23'd0);
    b_nan  = (b.exp == FP_EXP_INF) && (b.mant != 23'd0);
    r.hit  = 1'b1;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      r.value = FP_QNAN;
    end else if (a_zero) begin
      r.value = 32'd0;
    end else if (a_inf || b_zero) begin
      r.value = {s, FP_EXP_INF, 23'd0};
    end else if (b_inf) begin
      r.value = {s, 31'd0};
    end else begin
      r.hit   = 1'b0;
      r.value = 32'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_div_core.sv
// Fixed-latency iterative fp32 divider for finite, nonzero, normal operands.
// done pulses exactly DIV_CYCLES cycles after start (DIV_CYCLES >= 3).
module fp_div_core #(
  parameter int unsigned DIV_CYCLES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] result
);
  import fpu_pkg::*;

  localparam int unsigned FRAC_BITS = 25;
  localparam int unsigned ITER_CYC  = (DIV_CYCLES > 2) ? DIV_CYCLES - 2 : 1;
  localparam int unsigned STEPS     = (FRAC_BITS + ITER_CYC - 1) / ITER_CYC;
  localparam int unsigned CNT_W     = $clog2(DIV_CYCLES + 1);

  fp32_t              fa, fb;
  logic [23:0]        ma, mb;
  logic               ma_ge;
  logic               active_q, done_q, sign_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [4:0]         bits_q, bits_n;
  logic [24:0]        rem_q, rem_n;
  logic [25:0]        quo_q, quo_n, sh;
  logic [23:0]        mb_q;
  logic [9:0]         exp_q, exp_n, exp_r;
  logic               norm, guard, sticky;
  logic [23:0]        mant;
  logic [24:0]        rnd;
  logic [22:0]        mant_r;
  logic [31:0]        res_c, result_q;

  assign fa    = fp32_t'(a);
  assign fb    = fp32_t'(b);
  assign ma    = {1'b1, fa.mant};
  assign mb    = {1'b1, fb.mant};
  assign ma_ge = (ma >= mb);

  // STEPS restoring-division quotient bits per cycle until all fraction bits are done
  always_comb begin
    rem_n  = rem_q;
    quo_n  = quo_q;
    bits_n = bits_q;
    sh     = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      if (bits_n != 5'd0) begin
        sh = {rem_n, 1'b0};
        if (sh >= {2'b00, mb_q}) begin
          rem_n = 25'(sh - {2'b00, mb_q});
          quo_n = {quo_n[24:0], 1'b1};
        end else begin
          rem_n = 25'(sh);
          quo_n = {quo_n[24:0], 1'b0};
        end
        bits_n = bits_n - 5'd1;
      end
    end
  end

  // Normalise, round to nearest even, saturate to inf or flush to zero
  always_comb begin
    norm   = quo_q[25];
    mant   = norm ? quo_q[25:2] : quo_q[24:1];
    guard  = norm ? quo_q[1] : quo_q[0];
    sticky = (norm & quo_q[0]) | (rem_q != 25'd0);
    exp_n  = norm ? exp_q : exp_q - 10'd1;
    rnd    = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    exp_r  = rnd[24] ? exp_n + 10'd1 : exp_n;
    mant_r = rnd[24] ? rnd[23:1] : rnd[22:0];
    if ($signed(exp_r) >= 10'sd255) begin
      res_c = {sign_q, FP_EXP_INF, 23'd0};
    end else if ($signed(exp_r) <= 10'sd0) begin
      res_c = {sign_q, 31'd0};
    end else begin
      res_c = {sign_q, exp_r[7:0], mant_r};
    end
  end

  // Operand load, iteration countdown and done/result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      done_q   <= 1'b0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      bits_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      mb_q     <= '0;
      exp_q    <= '0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        active_q <= 1'b1;
        cnt_q    <= CNT_W'(DIV_CYCLES - 1);
        bits_q   <= 5'(FRAC_BITS);
        rem_q    <= ma_ge ? 25'(ma - mb) : 25'(ma);
        quo_q    <= 26'(ma_ge);
        mb_q     <= mb;
        exp_q    <= 10'(fa.exp) - 10'(fb.exp) + 10'(FP_EXP_BIAS);
        sign_q   <= fa.sign ^ fb.sign;
      end else if (active_q) begin
        cnt_q  <= cnt_q - CNT_W'(1);
        rem_q  <= rem_n;
        quo_q  <= quo_n;
        bits_q <= bits_n;
        if (cnt_q == CNT_W'(1)) begin
          done_q   <= 1'b1;
          result_q <= res_c;
          active_q <= 1'b0;
        end
      end
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: rtl/fp_div_arbiter.sv
// Two-requester round-robin front end sharing one fp32 divider, one op in flight.
module fp_div_arbiter #(
  parameter int unsigned DIV_CYCLES = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [63:0] rsp_data,
  output logic        busy
);
  import fpu_pkg::*;

  arb_state_e  state_q;
  logic        gnt_q, last_q, start_q, rsp_vld_q;
  logic [31:0] a_q, b_q, res_q;
  logic        grant_d;
  logic [31:0] a_d, b_d;
  fp_special_t spec_d;
  logic        core_done;
  logic [31:0] core_result;

  // Round-robin pick (ties go to the requester not served last) and operand mux
  always_comb begin
    grant_d = req_valid[1];
    if (req_valid == 2'b11) grant_d = ~last_q;
    a_d    = grant_d ? req_a[63:32] : req_a[31:0];
    b_d    = grant_d ? req_b[63:32] : req_b[31:0];
    spec_d = fp_div_special(fp32_t'(a_d), fp32_t'(b_d));
  end

  assign req_ready = (!rst && (state_q == ST_IDLE) && (|req_valid)) ?
                     (grant_d ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = {gnt_q & rsp_vld_q, ~gnt_q & rsp_vld_q};
  assign rsp_data  = gnt_q ? {res_q, 32'd0} : {32'd0, res_q};
  assign busy      = (state_q != ST_IDLE);

  // Accept / wait-for-core / hold-response state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      start_q   <= 1'b0;
      rsp_vld_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            gnt_q  <= grant_d;
            last_q <= grant_d;
            a_q    <= a_d;
            b_q    <= b_d;
            if (spec_d.hit) begin
              res_q     <= spec_d.value;
              rsp_vld_q <= 1'b1;
              state_q   <= ST_RESP;
            end else begin
              start_q <= 1'b1;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (core_done) begin
            res_q     <= core_result;
            rsp_vld_q <= 1'b1;
            state_q   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready[gnt_q]) begin
            rsp_vld_q <= 1'b0;
            res_q     <= '0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fp_div_core #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start_q),
    .a      (a_q),
    .b      (b_q),
    .done   (core_done),
    .result (core_result)
  );

endmodule
